sine_amplitude_sequencer: RTL and testbench

//   Envelope controller for the sine wave generator. Drives its Scale and

---
 rtl/sine_amplitude_sequencer_if.sv | 24 ++
 rtl/sine_amplitude_sequencer.sv | 134 +++++++++++++
 tb/tb_sine_amplitude_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sine_amplitude_sequencer_if.sv
// Control/status bundle between the user control logic (master) and the
// amplitude sequencer (slave) that feeds the sine generator.
interface sine_amplitude_sequencer_if #(
    parameter int HOLD_W = 16
);
    logic              start;
    logic              stop;
    logic [5:0]        Target_Scale;
    logic [HOLD_W-1:0] Hold_Steps;
    logic [5:0]        Scale;
    logic              Enable_SW_0;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, Target_Scale, Hold_Steps,
        input  Scale, Enable_SW_0, busy, done
    );

    modport slave (
        input  start, stop, Target_Scale, Hold_Steps,
        output Scale, Enable_SW_0, busy, done
    );
endinterface

// File: rtl/sine_amplitude_sequencer.sv
// Envelope controller for the sine generator: ramps Scale 0 -> target one LSB
// per tick, holds at the peak, then ramps back to 0 and pulses done.
module sine_amplitude_sequencer #(
    parameter int STEP_CYCLES = 50000,
    parameter int HOLD_W      = 16
) (
    input  logic                        sysclk,
    input  logic                        rst_n,
    sine_amplitude_sequencer_if.slave   bus
);

    localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  tick_count, tick_count_next;
    logic [HOLD_W-1:0] hold_count, hold_count_next;
    logic [HOLD_W-1:0] hold_lat, hold_lat_next;
    logic [5:0]        target_lat, target_lat_next;
    logic [5:0]        scale, scale_next;
    logic              enable, enable_next;
    logic              busy_q, busy_next;
    logic              done_q, done_next;
    logic              tick;

    assign tick = (tick_count == TICK_LAST);

    // The tick counter is free-running for the whole envelope so that a stop
    // keeps the step cadence; it is parked at 0 in IDLE, which also clears it
    // on an accepted start.
    always_comb begin
        state_next      = state;
        tick_count_next = tick_count;
        hold_count_next = hold_count;
        hold_lat_next   = hold_lat;
        target_lat_next = target_lat;
        scale_next      = scale;
        done_next       = 1'b0;

        if (state == IDLE || tick) begin
            tick_count_next = '0;
        end else begin
            tick_count_next = tick_count + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (bus.start && bus.Target_Scale != 6'd0) begin
                    state_next      = RAMP_UP;
                    target_lat_next = bus.Target_Scale;
                    hold_lat_next   = bus.Hold_Steps;
                end
            end
            RAMP_UP: begin
                if (tick) begin
                    scale_next = scale + 6'd1;
                end
                if (bus.stop) begin
                    state_next = RAMP_DOWN;
                end else if (tick && (scale + 6'd1) == target_lat) begin
                    state_next      = HOLD;
                    hold_count_next = hold_lat;
                end
            end
            HOLD: begin
                // A latched hold of 0 means stay at the peak until stop.
                if (bus.stop) begin
                    state_next = RAMP_DOWN;
                end else if (hold_lat != '0 && tick) begin
                    hold_count_next = hold_count - HOLD_W'(1);
                    if (hold_count == HOLD_W'(1)) begin
                        state_next = RAMP_DOWN;
                    end
                end
            end
            RAMP_DOWN: begin
                if (scale == 6'd0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (tick) begin
                    scale_next = scale - 6'd1;
                    if (scale == 6'd1) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                scale_next = 6'd0;
            end
        endcase

        busy_next   = (state_next != IDLE);
        enable_next = (state_next != IDLE);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_count <= '0;
            hold_count <= '0;
            hold_lat   <= '0;
            target_lat <= 6'd0;
            scale      <= 6'd0;
            enable     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            tick_count <= tick_count_next;
            hold_count <= hold_count_next;
            hold_lat   <= hold_lat_next;
            target_lat <= target_lat_next;
            scale      <= scale_next;
            enable     <= enable_next;
            busy_q     <= busy_next;
            done_q     <= done_next;
        end
    end

    assign bus.Scale       = scale;
    assign bus.Enable_SW_0 = enable;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_sine_amplitude_sequencer.sv
// Self-checking bench for sine_amplitude_sequencer; expected envelopes are
// computed in closed form from target, hold and the stop edge.
module tb_sine_amplitude_sequencer;

    localparam int S  = 4;
    localparam int HW = 16;
    localparam int NEVER = 32'h3fff_ffff;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #10 sysclk = ~sysclk;

    sine_amplitude_sequencer_if #(.HOLD_W(HW)) bus ();

    sine_amplitude_sequencer #(
        .STEP_CYCLES(S),
        .HOLD_W     (HW)
    ) dut (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Edge at which the ramp-down begins, counting the start edge as 0.
    function automatic int down_edge(int t, int h, int p);
        int e;
        e = (h == 0) ? NEVER : (t + h) * S;
        return (p > 0 && p < e) ? p : e;
    endfunction

    function automatic int peak_value(int t, int h, int p);
        int d;
        d = down_edge(t, h, p);
        return (d / S < t) ? d / S : t;
    endfunction

    function automatic int end_edge(int t, int h, int p);
        int d;
        d = down_edge(t, h, p);
        return (d / S + peak_value(t, h, p)) * S;
    endfunction

    // {Scale, Enable_SW_0, busy, done} expected just after edge n.
    function automatic logic [8:0] expected_at(int n, int t, int h, int p);
        int d, v, f, sc;
        d = down_edge(t, h, p);
        v = peak_value(t, h, p);
        f = end_edge(t, h, p);
        if (n < f) begin
            if (n <= d) sc = (n / S < t) ? n / S : t;
            else        sc = v - (n / S - d / S);
            return {6'(sc), 3'b110};
        end
        if (n == f) return {6'd0, 3'b001};
        return 9'd0;
    endfunction

    task automatic run_envelope(input int t, input int h, input int p,
                                input bit noise, input string name);
        int f, d;
        logic [8:0] exp_v, act_v;
        f = end_edge(t, h, p);
        d = down_edge(t, h, p);
        bus.Target_Scale = 6'(t);
        bus.Hold_Steps   = HW'(h);
        bus.start        = 1'b1;
        for (int n = 0; n <= f + 3; n++) begin
            if (n > 0) begin
                bus.start = 1'b0;
                bus.stop  = (n == p);
                if (noise && n < f) begin
                    bus.start        = ($urandom_range(0, 9) == 0);
                    bus.Target_Scale = 6'($urandom);
                    bus.Hold_Steps   = HW'($urandom_range(0, 5));
                    if (n > d && $urandom_range(0, 7) == 0) bus.stop = 1'b1;
                end
            end
            @(posedge sysclk);
            #1;
            exp_v = expected_at(n, t, h, p);
            act_v = {bus.Scale, bus.Enable_SW_0, bus.busy, bus.done};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL %s edge %0d: got scale=%0d en=%b busy=%b done=%b, expected scale=%0d en=%b busy=%b done=%b",
                         name, n, act_v[8:3], act_v[2], act_v[1], act_v[0],
                         exp_v[8:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] act_v;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge sysclk);
            #1;
            act_v = {bus.Scale, bus.Enable_SW_0, bus.busy, bus.done};
            checks++;
            if (act_v !== 9'd0) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got %b, expected 0", i, act_v);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_envelope();
        run_envelope(12, 3, -1, 1'b0, "full_envelope");
    endtask

    task automatic test_stop_mid_ramp();
        run_envelope(20, 0, 5 * S + 1, 1'b0, "stop_at_5");
    endtask

    task automatic test_max_hold_forever();
        run_envelope(63, 0, 63 * S + 1000, 1'b0, "peak_63");
    endtask

    task automatic test_ignored_requests();
        logic [8:0] act_v;
        bus.Target_Scale = 6'd0;
        bus.Hold_Steps   = HW'(2);
        bus.start        = 1'b1;
        @(posedge sysclk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge sysclk);
            #1;
            act_v = {bus.Scale, bus.Enable_SW_0, bus.busy, bus.done};
            checks++;
            if (act_v !== 9'd0) begin
                errors++;
                $display("[TB] FAIL target_zero cycle %0d: got %b, expected 0", i, act_v);
            end
        end
        run_envelope(10, 2, -1, 1'b1, "busy_noise");
    endtask

    task automatic test_start_with_stop();
        bus.stop = 1'b1;
        run_envelope(3, 1, -1, 1'b0, "start_and_stop");
    endtask

    task automatic test_reset_mid_hold();
        logic [8:0] act_v;
        bus.Target_Scale = 6'd12;
        bus.Hold_Steps   = HW'(3);
        bus.start        = 1'b1;
        for (int n = 0; n <= 55; n++) begin
            @(posedge sysclk);
            #1;
            bus.start = 1'b0;
        end
        checks++;
        if (bus.Scale !== 6'd12) begin
            errors++;
            $display("[TB] FAIL pre_reset_hold: got scale=%0d, expected 12", bus.Scale);
        end
        #5;
        rst_n = 1'b0;
        #1;
        act_v = {bus.Scale, bus.Enable_SW_0, bus.busy, bus.done};
        checks++;
        if (act_v !== 9'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b, expected 0", act_v);
        end
        @(posedge sysclk);
        @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        run_envelope(2, 1, -1, 1'b0, "after_reset");
    endtask

    task automatic test_random_envelopes();
        int t, h, p;
        string nm;
        for (int k = 0; k < 8; k++) begin
            t = int'($urandom_range(1, 20));
            h = int'($urandom_range(0, 5));
            if (h == 0)                          p = int'($urandom_range(S, (t + 5) * S));
            else if ($urandom_range(0, 1) == 1)  p = int'($urandom_range(S, (t + h) * S));
            else                                 p = -1;
            nm = $sformatf("random%0d_t%0d_h%0d_p%0d", k, t, h, p);
            run_envelope(t, h, p, 1'b1, nm);
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.Target_Scale = 6'd0;
        bus.Hold_Steps   = '0;
        test_reset();
        test_full_envelope();
        test_stop_mid_ramp();
        test_max_hold_forever();
        test_ignored_requests();
        test_start_with_stop();
        test_reset_mid_hold();
        test_random_envelopes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
